// File: rtl/mem_arb_pkg.sv
// Shared constants for the SRAM arbiter: address region codes and the
// default fill word returned for cpu data reads that miss the SRAM.
package mem_arb_pkg;

    typedef logic [3:0] region_t;

    localparam region_t REGION_SRAM = 4'h0;
    localparam region_t REGION_VRAM = 4'h8;
    localparam region_t REGION_CTRL = 4'hF;

    localparam logic [15:0] RD_FILL_DEFAULT = 16'hEEEE;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, SRAM and write-strobe signals around mem_arbiter.
// slave = arbiter side, master = surrounding system (cpu, debug, SRAM).
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [AW-1:0] ins_rd_addr;
    logic          ins_rd_req;
    logic          ins_rd_rdy;
    logic [DW-1:0] ins_rd_data;

    logic [AW-1:0] dat_rw_addr;
    logic          dat_rd_req;
    logic          dat_rd_rdy;
    logic [DW-1:0] dat_rd_data;
    logic [DW-1:0] dat_wr_data;
    logic          dat_wr_req;
    logic          dat_wr_rdy;

    logic          dbg_we;
    logic [AW-1:0] dbg_waddr;
    logic [DW-1:0] dbg_wdata;

    logic [AW-1:0] mem_raddr;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          sram_we;
    logic          vram_we;
    logic          ctrl_we;

    modport slave (
        input  ins_rd_addr, ins_rd_req, dat_rw_addr, dat_rd_req, dat_wr_data,
               dat_wr_req, dbg_we, dbg_waddr, dbg_wdata, mem_rdata,
        output ins_rd_rdy, ins_rd_data, dat_rd_rdy, dat_rd_data, dat_wr_rdy,
               mem_raddr, mem_re, waddr, wdata, sram_we, vram_we, ctrl_we
    );

    modport master (
        output ins_rd_addr, ins_rd_req, dat_rw_addr, dat_rd_req, dat_wr_data,
               dat_wr_req, dbg_we, dbg_waddr, dbg_wdata, mem_rdata,
        input  ins_rd_rdy, ins_rd_data, dat_rd_rdy, dat_rd_data, dat_wr_rdy,
               mem_raddr, mem_re, waddr, wdata, sram_we, vram_we, ctrl_we
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin: combinational grant, pointer remembers the
// loser of the last contention and only moves when both request.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_p1;

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = ptr_p1 ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (reset)              ptr_p1 <= 1'b0;
        else if (req == 2'b11)  ptr_p1 <= ~ptr_p1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// SRAM read/write port arbiter for cpu16 fetch/data and SPI debug writes.
// Optional stall counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int            AW      = 16,
    parameter int            DW      = 16,
    parameter logic [DW-1:0] RD_FILL = DW'(RD_FILL_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
   ,output logic [15:0]   ins_stall_cnt,
    output logic [15:0]   dat_stall_cnt,
    output logic [15:0]   wr_stall_cnt
`endif
);

    region_t       dat_region, wr_region;
    logic          dat_rd_eff, dat_is_sram, dat_fill;
    logic [1:0]    rd_req, rd_gnt;
    logic          cpu_wr_go, wr_active;
    logic [AW-1:0] wr_addr;

    logic          ins_rdy_p1, dat_rdy_p1, dat_sram_p1, wr_rdy_p1;
    logic [DW-1:0] ins_hold_p1, dat_hold_p1, dat_rsp;

    // A write from the cpu masks its own read request that cycle.
    always_comb begin
        dat_region  = bus.dat_rw_addr[AW-1 -: 4];
        dat_rd_eff  = bus.dat_rd_req & ~bus.dat_wr_req;
        dat_is_sram = (dat_region == REGION_SRAM);
        rd_req      = reset ? 2'b00 : {dat_rd_eff & dat_is_sram, bus.ins_rd_req};
        dat_fill    = ~reset & dat_rd_eff & ~dat_is_sram;
    end

    rr_arb2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    assign bus.mem_re    = |rd_gnt;
    assign bus.mem_raddr = rd_gnt[1] ? bus.dat_rw_addr : bus.ins_rd_addr;

    // Debug wins the write port; ctrl_we stays live in reset so debug can release the cpu.
    always_comb begin
        wr_addr     = bus.dbg_we ? bus.dbg_waddr : bus.dat_rw_addr;
        wr_region   = wr_addr[AW-1 -: 4];
        cpu_wr_go   = bus.dat_wr_req & ~bus.dbg_we & ~reset;
        wr_active   = bus.dbg_we | cpu_wr_go;
        bus.waddr   = wr_addr;
        bus.wdata   = bus.dbg_we ? bus.dbg_wdata : bus.dat_wr_data;
        bus.sram_we = ~reset & wr_active & (wr_region == REGION_SRAM);
        bus.vram_we = ~reset & wr_active & (wr_region == REGION_VRAM);
        bus.ctrl_we = wr_active & (wr_region == REGION_CTRL);
    end

    // ---- completion stage: grant in N -> rdy in N+1 ----
    always_ff @(posedge clk) begin
        if (reset) begin
            ins_rdy_p1  <= 1'b0;
            dat_rdy_p1  <= 1'b0;
            dat_sram_p1 <= 1'b0;
            wr_rdy_p1   <= 1'b0;
            ins_hold_p1 <= '0;
            dat_hold_p1 <= '0;
        end else begin
            ins_rdy_p1  <= rd_gnt[0];
            dat_rdy_p1  <= rd_gnt[1] | dat_fill;
            dat_sram_p1 <= rd_gnt[1];
            wr_rdy_p1   <= cpu_wr_go;
            if (ins_rdy_p1) ins_hold_p1 <= bus.mem_rdata;
            if (dat_rdy_p1) dat_hold_p1 <= dat_rsp;
        end
    end

    // SRAM data arrives in the completion cycle; the hold register keeps it stable afterwards.
    assign dat_rsp         = dat_sram_p1 ? bus.mem_rdata : RD_FILL;
    assign bus.ins_rd_rdy  = ins_rdy_p1;
    assign bus.ins_rd_data = ins_rdy_p1 ? bus.mem_rdata : ins_hold_p1;
    assign bus.dat_rd_rdy  = dat_rdy_p1;
    assign bus.dat_rd_data = dat_rdy_p1 ? dat_rsp : dat_hold_p1;
    assign bus.dat_wr_rdy  = wr_rdy_p1;

`ifdef MEM_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            ins_stall_cnt <= '0;
            dat_stall_cnt <= '0;
            wr_stall_cnt  <= '0;
        end else begin
            ins_stall_cnt <= sat_inc(ins_stall_cnt, bus.ins_rd_req & ~rd_gnt[0]);
            dat_stall_cnt <= sat_inc(dat_stall_cnt, bus.dat_rd_req & ~(rd_gnt[1] | dat_fill));
            wr_stall_cnt  <= sat_inc(wr_stall_cnt, bus.dat_wr_req & bus.dbg_we);
        end
    end
`endif

endmodule
